// File: rtl/srff_bank_arbiter_if.sv
// Requester-side bundle for the shared SR flag bank: per-requester request and
// packed set/clear masks in, one-hot grant plus bank status out.
interface srff_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] set_mask;
    logic [NREQ*WIDTH-1:0] clr_mask;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic                  err;

    modport master (
        output req, set_mask, clr_mask,
        input  gnt, busy, q, err
    );

    modport slave (
        input  req, set_mask, clr_mask,
        output gnt, busy, q, err
    );
endinterface

// File: rtl/srff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit SR flag bank between NREQ requesters;
// the winner's masks are captured in IDLE and applied one cycle later in APPLY.
module srff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    srff_bank_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic {IDLE, APPLY} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [PW-1:0]    win;
    logic [PW:0]      idx;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [WIDTH-1:0] creg, creg_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH-1:0] conf;
    logic [NREQ-1:0]  gnt, gnt_n;
    logic             busy, busy_n;
    logic             err, err_n;

    logic [WIDTH-1:0] set_arr [NREQ];
    logic [WIDTH-1:0] clr_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign set_arr[i] = bus.set_mask[i*WIDTH +: WIDTH];
        assign clr_arr[i] = bus.clr_mask[i*WIDTH +: WIDTH];
    end

    // Scan ptr, ptr+1, ... downwards so the nearest requester to ptr is written last and wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ))
                idx = idx - (PW+1)'(NREQ);
            if (bus.req[idx[PW-1:0]])
                win = idx[PW-1:0];
        end
    end

    assign conf = sreg & creg;

    always_comb begin
        // NOTE: every next-state value gets a default before the case, so no path leaves one unassigned and infers a latch.
        state_n = state;
        ptr_n   = ptr;
        sreg_n  = sreg;
        creg_n  = creg;
        q_n     = q;
        gnt_n   = '0;
        busy_n  = 1'b0;
        err_n   = 1'b0;

        unique case (state)
            IDLE: begin
                if (|bus.req) begin
                    sreg_n     = set_arr[win];
                    creg_n     = clr_arr[win];
                    gnt_n[win] = 1'b1;
                    busy_n     = 1'b1;
                    state_n    = APPLY;
                    ptr_n      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
            end
            APPLY: begin
                // Bits with both set and clear asserted are held rather than entering the illegal SR state.
                q_n     = (q & ~(creg & ~conf)) | (sreg & ~conf);
                err_n   = |conf;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only here, so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sreg  <= '0;
            creg  <= '0;
            q     <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sreg  <= sreg_n;
            creg  <= creg_n;
            q     <= q_n;
            gnt   <= gnt_n;
            busy  <= busy_n;
            err   <= err_n;
        end
    end

    assign bus.gnt  = gnt;
    assign bus.busy = busy;
    assign bus.q    = q;
    assign bus.err  = err;
endmodule

// File: doc/srff_bank_arbiter.md
Name: srff_bank_arbiter

Overview:
- Shares one WIDTH-bit bank of SR flip-flops between NREQ requesters.
- Each requester presents a set mask and a clear mask. A round-robin arbiter picks one request at a time and applies its masks to the bank as per-bit s/r.
- Per-bit s=1/r=1 conflicts are masked so the bank never enters the illegal SR state.
- Sits between control agents and the shared status/flag register built from SR cells.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, bits in the shared SR bank (1..32)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  NREQ  per-requester request, level
- set_mask  input  NREQ*WIDTH  requester i's set mask in bits [i*WIDTH +: WIDTH]
- clr_mask  input  NREQ*WIDTH  requester i's clear mask, same packing
- gnt  output  NREQ  one-hot grant, registered
- busy  output  1  high while in APPLY
- q  output  WIDTH  SR bank contents
- err  output  1  one-cycle pulse: granted masks had at least one bit with set=clr=1

Behaviour:
- Reset (sampled at posedge clk while rst=1):
  - q=0, gnt=0, busy=0, err=0, ptr=0, state=IDLE.
  - rst overrides everything. A reset during APPLY discards the pending update, and q stays 0.
- FSM states are IDLE and APPLY.
- IDLE:
  - If req==0, stay in IDLE and hold all outputs (gnt=0, err=0).
  - Else select the winner w: the first index with req[w]=1 scanning ptr, ptr+1, ..., wrapping mod NREQ.
  - At the edge:
    - latch set_mask[w] into sreg and clr_mask[w] into creg;
    - gnt <= one-hot(w), busy <= 1, state <= APPLY;
    - ptr <= (w+1) mod NREQ, wrapping from NREQ-1 to 0.
- APPLY (exactly one cycle):
  - At the edge:
    - conf = sreg & creg;
    - q <= (q & ~(creg & ~conf)) | (sreg & ~conf);
    - err <= |conf;
    - gnt <= 0, busy <= 0, state <= IDLE.
  - req and masks are ignored in APPLY.
- Per-bit results:
  - s=1, r=0 sets the bit.
  - s=0, r=1 clears the bit.
  - s=0, r=0 holds the bit.
  - s=1, r=1 holds the bit and raises err.
- Handshake:
  - A requester holds req and its masks stable until it sees gnt high.
  - It must drop req (or present a new request) by the next edge.
  - Masks are captured at the IDLE edge, so they may change once gnt is seen.
- Timing:
  - Latency is 2 edges from req sampled in IDLE to q updated.
  - gnt is high for exactly one cycle, and q changes on the same edge that gnt falls.
  - Throughput is at most one grant per 2 cycles.
- err is high only in the cycle after APPLY and is cleared on the next edge.
- Fairness: any requester holding req continuously is granted within NREQ grants.
- Simultaneous requests: the winner is decided only by ptr.
- A single continuous requester is re-granted every 2 cycles.

Test Plan:
- Reset with req=0 -> q=0, gnt=0, busy=0, err=0. Hold 5 cycles idle -> no change.
- req=0001, set_mask[0]=8'hA5, clr_mask[0]=0 -> gnt=0001 for 1 cycle, then q=8'hA5 and err=0. Then req0 with clr_mask[0]=8'h0F -> q=8'hA0.
- req=1111 held continuously, all masks 0 -> grant order 0001, 0010, 0100, 1000, 0001; a grant every 2 cycles; ptr wraps 3->0.
- From q=8'hF0: set=8'h3C, clr=8'h3C -> q stays 8'hF0, err pulses 1 for one cycle. From q=8'hF0: set=8'h0F, clr=8'h30 -> q=8'hCF, err=0.
- ptr=2 (after granting req1), then req=0011 -> gnt=0001 (wrap past idle 2 and 3), then ptr=1.
- rst asserted during APPLY with set=8'hFF -> q=0, gnt=0, busy=0 next cycle. Arbitration restarts at requester 0.
